outerprodrc_ctrl: RTL
=====================

// Module: outerprodrc_ctrl
// PURPOSE
// - Job sequencer for the unary outer-product array (sign-magnitude operands, binary counter outputs).
// - Accepts one operand pair per job via a valid/ready handshake and latches it.
// - Drives the array's enable and clear inputs for one job, then flags the result valid until it is consumed.
// - Sits between the GEMM tile scheduler (upstream) and the array instance (downstream).
// PARAMETERS
// - ROWNUM    4  rows in the array (elements of the row operand vector)
// - COLNUM    4  columns in the array (elements of the column operand vector)
// - BITWIDTH  8  operand width, MSB is sign; full stream length L_FULL = 2**(BITWIDTH-1)
// PORTS
// - iClk     in   1                  clock, rising edge
// - iRstN    in   1                  asynchronous reset, active low
// - iValid   in   1                  upstream job request
// - oReady   out  1                  controller can accept a job (IDLE only)
// - iData0   in   ROWNUM*BITWIDTH    row operand vector, sampled on accept
// - iData1   in   COLNUM*BITWIDTH    column operand vector, sampled on accept
// - iAbort   in   1                  cancel the current job
// - oData0   out  ROWNUM*BITWIDTH    latched row vector to array iData0
// - oData1   out  COLNUM*BITWIDTH    latched column vector to array iData1
// - oClr     out  1                  to array iClr
// - oEn      out  1                  to array iEn
// - oValid   out  1                  array oData holds a finished job result
// - iReady   in   1                  downstream consumes result
// - oBusy    out  1                  high in CLEAR, RUN and DONE
// BEHAVIOUR
// - Reset: state IDLE; oData0, oData1 and the length counter are 0; oClr, oEn, oValid and oBusy are 0; oReady is 1.
// - FSM states: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
// - IDLE: oReady=1. When iValid&oReady, latch iData0/iData1 into oData0/oData1, load the length counter, go to CLEAR.
// - CLEAR: exactly 1 cycle, oClr=1, oEn=0. Zeroes the array accumulators.
// - RUN: oEn=1 for exactly L cycles. The counter decrements each cycle; on count 1, go to DONE.
// - DONE: oValid=1, held until iReady. On oValid&iReady, go to IDLE; oValid drops the next cycle.
// - Latency: accept edge at cycle t; oClr high in t+1; oEn high in t+2..t+1+L; oValid first high in t+2+L.
// - oData0/oData1 are stable from accept until the next accept, including through DONE.
// - iValid outside IDLE is ignored; no queueing. iData0/iData1 are don't-care when not accepted.
// - iAbort in CLEAR or RUN: the next state is IDLE, oEn drops the next cycle, and oValid is never raised.
// - iAbort in IDLE or DONE has no effect; a result in DONE still waits for iReady.
// - iAbort on the last RUN cycle wins over the RUN -> DONE transition.
// - iAbort together with iValid in IDLE: the job is accepted normally.
// - Sobol RNG state in the array is not reset between jobs; the stream continues, which is by design.
// - Asynchronous reset mid-job returns to IDLE immediately; no oValid is produced for the lost job.
// - Counter width is BITWIDTH bits; it never wraps (it loads L >= 1 and stops at 1).
// CONFIGURATION
// - OUTERPRODRC_CTRL_EARLYTERM_EN defined:
//   - Adds input port iLen [BITWIDTH-1:0], sampled on accept, with L = iLen.
//   - iLen==0 or iLen>L_FULL gives L = L_FULL.
//   - Early termination trades accuracy for latency.
// - OUTERPRODRC_CTRL_EARLYTERM_EN undefined: no iLen port; L = L_FULL always.
// TESTING (BITWIDTH=8, L_FULL=128, ROWNUM=COLNUM=4)
// - Reset held, then released:
//   - oReady=1, oValid=0, oEn=0, oClr=0, oData0=0.
//   - After 10 idle cycles, nothing changes.
// - Single job accepted at cycle t, iReady=1 throughout:
//   - oClr=1 at t+1 only; oEn=1 for exactly 128 cycles (t+2..t+129).
//   - oValid=1 at t+130 for 1 cycle; oReady=1 at t+131.
// - Backpressure: iReady=0 for 20 cycles in DONE:
//   - oValid, oData0 and oData1 held constant; a concurrent iValid is ignored (oReady=0).
//   - iReady=1 -> return to IDLE.
// - iAbort asserted on RUN cycle 50:
//   - oEn=0 next cycle, state IDLE, oValid never 1.
//   - A new job is then accepted and completes normally.
// - iAbort on the 128th oEn cycle -> IDLE, no oValid.
//   - With EARLYTERM_EN: iLen=16 -> 16 oEn cycles; iLen=0 -> 128; iLen=200 -> 128.
// - Asynchronous reset pulse mid-RUN -> outputs reach reset values with no clock edge needed.
// - End-to-end with the array:
//   - Operand 0x40 (+64/128) times 0x40, 128 cycles -> count ~32 (within +/-2), sign 0.
//   - Operand 0xC0 times 0x40 -> sign 1.

Source files
------------

// File: rtl/outerprodrc_ctrl.sv
// outerprodrc_ctrl: job sequencer for the unary outer-product array.
// Accepts one sign-magnitude operand pair per job. It clears the array accumulators,
// enables the array for L cycles, then presents the result until downstream consumes it.
// Optional feature: define OUTERPRODRC_CTRL_EARLYTERM_EN to add the iLen port.
// iLen sets a per-job stream length.
// L = iLen when 1 <= iLen <= L_FULL, otherwise L = L_FULL. L_FULL = 2**(BITWIDTH-1).
module outerprodrc_ctrl #(
    parameter int ROWNUM   = 4,
    parameter int COLNUM   = 4,
    parameter int BITWIDTH = 8
) (
    input  logic                         iClk,
    input  logic                         iRstN,
    input  logic                         iValid,
    output logic                         oReady,
    input  logic [ROWNUM*BITWIDTH-1:0]   iData0,
    input  logic [COLNUM*BITWIDTH-1:0]   iData1,
    input  logic                         iAbort,
`ifdef OUTERPRODRC_CTRL_EARLYTERM_EN
    input  logic [BITWIDTH-1:0]          iLen,
`endif
    output logic [ROWNUM*BITWIDTH-1:0]   oData0,
    output logic [COLNUM*BITWIDTH-1:0]   oData1,
    output logic                         oClr,
    output logic                         oEn,
    output logic                         oValid,
    input  logic                         iReady,
    output logic                         oBusy
);

    localparam int                  LFULL     = 2 ** (BITWIDTH - 1);
    localparam logic [BITWIDTH-1:0] LFULL_W   = BITWIDTH'(LFULL);
    localparam logic [BITWIDTH-1:0] CNT_LAST  = BITWIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    state_t              stateNext;
    logic [BITWIDTH-1:0] lenCnt;
    logic [BITWIDTH-1:0] lenLoad;
    logic                accept;

    assign accept = iValid & oReady;

    // Stream length for the job being accepted.
    always_comb begin
`ifdef OUTERPRODRC_CTRL_EARLYTERM_EN
        if ((iLen == '0) || (iLen > LFULL_W)) begin
            lenLoad = LFULL_W;
        end else begin
            lenLoad = iLen;
        end
`else
        lenLoad = LFULL_W;
`endif
    end

    // State register.
    always_ff @(posedge iClk or negedge iRstN) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of block ordering.
        if (!iRstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic. Abort in CLEAR/RUN overrides every other transition.
    always_comb begin
        // NOTE: the default assignment up front keeps this block free of latches
        // on paths that do not assign stateNext explicitly.
        stateNext = state;
        unique case (state)
            IDLE:  if (accept) stateNext = CLEAR;
            CLEAR: stateNext = iAbort ? IDLE : RUN;
            RUN: begin
                if (iAbort) begin
                    stateNext = IDLE;
                end else if (lenCnt == CNT_LAST) begin
                    stateNext = DONE;
                end
            end
            DONE:  if (iReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Moore outputs decoded from the state.
    always_comb begin
        oReady = (state == IDLE);
        oClr   = (state == CLEAR);
        oEn    = (state == RUN);
        oValid = (state == DONE);
        oBusy  = (state != IDLE);
    end

    // Operand latches and length counter.
    // The operands hold from one accept to the next, so they stay valid through DONE.
    always_ff @(posedge iClk or negedge iRstN) begin
        // NOTE: the operand registers are reset on purpose.
        // The array sees a defined all-zero vector before the first job is accepted.
        if (!iRstN) begin
            oData0 <= '0;
            oData1 <= '0;
            lenCnt <= '0;
        end else if (accept) begin
            oData0 <= iData0;
            oData1 <= iData1;
            lenCnt <= lenLoad;
        end else if ((state == RUN) && (lenCnt != CNT_LAST)) begin
            lenCnt <= lenCnt - CNT_LAST;
        end
    end

endmodule
